// File: rtl/tx_code_group_seq.sv
// PCS transmit code-group sequencer: expands the requested ordered set into one octet+K flag per GTX_CLK.
// Define TX_CONFIG_EN to compile in /C/ generation; otherwise tx_os_C is handled exactly like tx_os_I.
module tx_code_group_seq (
  input  logic        GTX_CLK,
  input  logic        mr_main_reset,
  input  logic [6:0]  tx_o_set,
  input  logic [7:0]  TXD,
  input  logic [15:0] tx_config_reg,
  input  logic        tx_disparity,
  output logic [7:0]  tx_octet,
  output logic        tx_is_k,
  output logic        tx_even,
  output logic        TX_OSET_indicate
);

  // Ordered-set request codes, one-hot as in macros_TX.v
  localparam logic [6:0] TX_OS_I = 7'b000_0001;
  localparam logic [6:0] TX_OS_S = 7'b000_0010;
  localparam logic [6:0] TX_OS_T = 7'b000_0100;
  localparam logic [6:0] TX_OS_R = 7'b000_1000;
  localparam logic [6:0] TX_OS_V = 7'b001_0000;
  localparam logic [6:0] TX_OS_D = 7'b010_0000;
  localparam logic [6:0] TX_OS_C = 7'b100_0000;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K30_7 = 8'hFE;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;
`ifdef TX_CONFIG_EN
  localparam logic [7:0] D21_5 = 8'hB5;
  localparam logic [7:0] D2_2  = 8'h42;
`endif

  typedef enum logic [2:0] {
    GEN,
    IDLE_A,
    IDLE_B,
    FILL
`ifdef TX_CONFIG_EN
    , CFG_A,
    CFG_B,
    CFG_C,
    CFG_D
`endif
  } state_t;

  state_t     state;
  logic       idle_i1;
  logic       req_align;
  logic [7:0] gen_octet;
  logic       gen_k;

`ifdef TX_CONFIG_EN
  logic        req_cfg;
  logic        pend_cfg;
  logic [15:0] cfg_word;
  logic        use_c2;
`else
  logic        unused_cfg;
  assign unused_cfg = ^tx_config_reg;
`endif

  // Request decode; req_align marks the multi-code-group sets that must start on an even slot.
  always_comb begin
    req_align = 1'b0;
    gen_octet = K30_7;
    gen_k     = 1'b1;
`ifdef TX_CONFIG_EN
    req_cfg   = 1'b0;
`endif
    case (tx_o_set)
      TX_OS_I: req_align = 1'b1;
      TX_OS_C: begin
        req_align = 1'b1;
`ifdef TX_CONFIG_EN
        req_cfg   = 1'b1;
`endif
      end
      TX_OS_S: gen_octet = K27_7;
      TX_OS_T: gen_octet = K29_7;
      TX_OS_R: gen_octet = K23_7;
      TX_OS_V: gen_octet = K30_7;
      TX_OS_D: begin
        gen_octet = TXD;
        gen_k     = 1'b0;
      end
      default: gen_octet = K30_7;
    endcase
  end

  always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      state            <= IDLE_A;
      tx_octet         <= K28_5;
      tx_is_k          <= 1'b1;
      tx_even          <= 1'b1;
      TX_OSET_indicate <= 1'b0;
      idle_i1          <= 1'b0;
`ifdef TX_CONFIG_EN
      pend_cfg         <= 1'b0;
      cfg_word         <= '0;
      use_c2           <= 1'b0;
`endif
    end else begin
      tx_even          <= ~tx_even;
      tx_octet         <= K28_5;
      tx_is_k          <= 1'b1;
      TX_OSET_indicate <= 1'b0;
      case (state)
        IDLE_A: begin
          state            <= IDLE_B;
          tx_octet         <= idle_i1 ? D5_6 : D16_2;
          tx_is_k          <= 1'b0;
          TX_OSET_indicate <= 1'b1;
        end
        FILL: begin
`ifdef TX_CONFIG_EN
          state <= pend_cfg ? CFG_A : IDLE_A;
`else
          state <= IDLE_A;
`endif
        end
`ifdef TX_CONFIG_EN
        CFG_A: begin
          state    <= CFG_B;
          tx_octet <= use_c2 ? D2_2 : D21_5;
          tx_is_k  <= 1'b0;
          use_c2   <= ~use_c2;
        end
        CFG_B: begin
          state    <= CFG_C;
          tx_octet <= cfg_word[7:0];
          tx_is_k  <= 1'b0;
        end
        CFG_C: begin
          state            <= CFG_D;
          tx_octet         <= cfg_word[15:8];
          tx_is_k          <= 1'b0;
          TX_OSET_indicate <= 1'b1;
        end
`endif
        // GEN, IDLE_B and CFG_D hold the last code-group of a set: sample the next request.
        default: begin
          if (req_align) begin
            idle_i1  <= tx_disparity;
`ifdef TX_CONFIG_EN
            pend_cfg <= req_cfg;
            cfg_word <= tx_config_reg;
`endif
            if (tx_even) begin
              state    <= FILL;
              tx_octet <= K23_7;
            end else begin
`ifdef TX_CONFIG_EN
              state <= req_cfg ? CFG_A : IDLE_A;
`else
              state <= IDLE_A;
`endif
            end
          end else begin
            state            <= GEN;
            tx_octet         <= gen_octet;
            tx_is_k          <= gen_k;
            TX_OSET_indicate <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_code_group_seq.sv
// Scoreboard bench for tx_code_group_seq: a set-level reference model predicts each code-group,
// a separate monitor compares it against the DUT one time unit after every rising edge.
module tb_tx_code_group_seq;

  localparam logic [6:0] OS_I = 7'h01;
  localparam logic [6:0] OS_S = 7'h02;
  localparam logic [6:0] OS_T = 7'h04;
  localparam logic [6:0] OS_R = 7'h08;
  localparam logic [6:0] OS_V = 7'h10;
  localparam logic [6:0] OS_D = 7'h20;
  localparam logic [6:0] OS_C = 7'h40;
`ifdef TX_CONFIG_EN
  localparam bit CFG_EN = 1'b1;
`else
  localparam bit CFG_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] octet;
    logic       k;
    logic       even;
    logic       ind;
  } cg_t;

  typedef struct {
    logic [6:0]  oset;
    logic [7:0]  txd;
    logic [15:0] cfg;
    logic        disp;
    logic        abort;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  tx_o_set = OS_I;
  logic [7:0]  TXD = '0;
  logic [15:0] cfg = '0;
  logic        disp = 1'b0;
  logic [7:0]  tx_octet;
  logic        tx_is_k;
  logic        tx_even;
  logic        ind;

  tx_code_group_seq dut (
    .GTX_CLK         (clk),
    .mr_main_reset   (rst),
    .tx_o_set        (tx_o_set),
    .TXD             (TXD),
    .tx_config_reg   (cfg),
    .tx_disparity    (disp),
    .tx_octet        (tx_octet),
    .tx_is_k         (tx_is_k),
    .tx_even         (tx_even),
    .TX_OSET_indicate(ind)
  );

  always #5 clk = ~clk;

  cg_t         exp_q[$];
  cg_t         pend[$];
  req_t        req_q[$];
  int unsigned slot = 0;
  bit          c2 = 1'b0;
  bit          abort_armed = 1'b0;
  bit          done = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic void check(string name, logic [15:0] act, logic [15:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic cg_t mk(logic [7:0] o, logic k, logic i);
    cg_t g;
    g.octet = o;
    g.k     = k;
    g.even  = 1'b0;
    g.ind   = i;
    return g;
  endfunction

  function automatic req_t mkreq(logic [6:0] o, logic [7:0] d, logic [15:0] c, logic p, logic a);
    req_t r;
    r.oset  = o;
    r.txd   = d;
    r.cfg   = c;
    r.disp  = p;
    r.abort = a;
    return r;
  endfunction

  function automatic req_t rand_req();
    int unsigned sel;
    logic [6:0]  o;
    sel = $urandom_range(0, 9);
    if (sel < 7)       o = 7'(1 << sel);
    else if (sel == 7) o = 7'($urandom);
    else if (sel == 8) o = OS_I;
    else               o = OS_C;
    return mkreq(o, 8'($urandom), 16'($urandom), 1'($urandom), 1'b0);
  endfunction

  // Expand a sampled request into its code-groups; slot is the slot the first one lands in.
  function automatic void start_set(req_t r);
    logic [7:0] seq[$];
    if (r.oset == OS_I || r.oset == OS_C) begin
      seq.push_back(8'hBC);
      if (r.oset == OS_C && CFG_EN) begin
        seq.push_back(c2 ? 8'h42 : 8'hB5);
        seq.push_back(r.cfg[7:0]);
        seq.push_back(r.cfg[15:8]);
        c2 = !c2;
      end else begin
        seq.push_back(r.disp ? 8'hC5 : 8'h50);
      end
      if (slot % 2 == 1) pend.push_back(mk(8'hF7, 1'b1, 1'b0));
      for (int i = 0; i < seq.size(); i++)
        pend.push_back(mk(seq[i], i == 0, i == seq.size() - 1));
    end else begin
      case (r.oset)
        OS_S:    pend.push_back(mk(8'hFB, 1'b1, 1'b1));
        OS_T:    pend.push_back(mk(8'hFD, 1'b1, 1'b1));
        OS_R:    pend.push_back(mk(8'hF7, 1'b1, 1'b1));
        OS_D:    pend.push_back(mk(r.txd, 1'b0, 1'b1));
        default: pend.push_back(mk(8'hFE, 1'b1, 1'b1));
      endcase
    end
    abort_armed = r.abort;
  endfunction

  task automatic apply(req_t r);
    tx_o_set = r.oset;
    TXD      = r.txd;
    cfg      = r.cfg;
    disp     = r.disp;
  endtask

  task automatic reset_model();
    exp_q.delete();
    pend.delete();
    slot        = 0;
    c2          = 1'b0;
    abort_armed = 1'b0;
    pend.push_back(mk(8'h50, 1'b0, 1'b1));
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_octet"}, tx_octet, 8'hBC);
    check({tag, "_is_k"}, tx_is_k, 1'b1);
    check({tag, "_even"}, tx_even, 1'b1);
    check({tag, "_indicate"}, ind, 1'b0);
  endtask

  initial begin
    req_t cur;
    cg_t  g;
    repeat (3) req_q.push_back(mkreq(OS_I, 8'h00, 16'h0000, 1'b0, 1'b0));
    repeat (3) req_q.push_back(mkreq(OS_I, 8'h00, 16'h0000, 1'b1, 1'b0));
    req_q.push_back(mkreq(OS_S, 8'h00, 16'h0000, 1'b0, 1'b0));
    req_q.push_back(mkreq(OS_D, 8'h55, 16'h0000, 1'b0, 1'b0));
    req_q.push_back(mkreq(OS_D, 8'hAA, 16'h0000, 1'b0, 1'b0));
    req_q.push_back(mkreq(OS_T, 8'h00, 16'h0000, 1'b0, 1'b0));
    req_q.push_back(mkreq(OS_R, 8'h00, 16'h0000, 1'b0, 1'b0));
    req_q.push_back(mkreq(OS_I, 8'h00, 16'h0000, 1'b0, 1'b0));
    repeat (3) req_q.push_back(mkreq(OS_C, 8'h00, 16'h1234, 1'b0, 1'b0));
    req_q.push_back(mkreq(OS_C, 8'h00, 16'h1234, 1'b0, 1'b1));
    repeat (400) req_q.push_back(rand_req());

    #1 rst = 1'b1;
    #2 check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset_model();
    rst = 1'b0;

    for (int cyc = 0; cyc < 5000 && req_q.size() > 0; cyc++) begin
      if (pend.size() == 0) cur = req_q.pop_front();
      else                  cur = rand_req();
      apply(cur);
      @(posedge clk);
      slot++;
      if (pend.size() == 0) start_set(cur);
      g = pend.pop_front();
      g.even = (slot % 2 == 0);
      exp_q.push_back(g);
      if (abort_armed && pend.size() == 1) begin
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_set_reset");
        @(posedge clk);
        @(negedge clk);
        reset_model();
        rst = 1'b0;
      end else begin
        @(negedge clk);
      end
    end

    done = 1'b1;
    check("requests_consumed", 16'(req_q.size()), 16'd0);
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    cg_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst || done) continue;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL no_expectation: got octet %0h, expected a predicted code-group at %0t", tx_octet, $time);
      end else begin
        e = exp_q.pop_front();
        check("octet", tx_octet, e.octet);
        check("is_k", tx_is_k, e.k);
        check("even", tx_even, e.even);
        check("oset_indicate", ind, e.ind);
      end
    end
  end

endmodule

// File: doc/tx_code_group_seq.md
# tx_code_group_seq

PCS transmit code-group sequencer: converts the ordered set currently requested on `tx_o_set` (plus `TXD` for /D/) into a stream of one code-group per `GTX_CLK`, in octet-plus-K-flag form. It sits between the transmit ordered-set state machine and the 8B/10B encoder. It paces the ordered-set machine through `TX_OSET_indicate`, owns the even/odd code-group phase `tx_even`, and selects /I1/ or /I2/ from the encoder's running disparity.

## Interface
- Parameters: none. Ordered-set codes are the `tx_os_*` encodings from `macros_TX.v`.
- `GTX_CLK` in 1: transmit clock; every output is registered on its rising edge.
- `mr_main_reset` in 1: asynchronous, active-high reset.
- `tx_o_set` in 7: requested ordered set (`tx_os_I/S/T/R/V/D/C`).
- `TXD` in 8: data octet, used when `tx_o_set`=`tx_os_D`.
- `tx_config_reg` in 16: configuration word for /C/.
- `tx_disparity` in 1: encoder running disparity after the code-group currently on the outputs (1=positive).
- `tx_octet` out 8: code-group octet to the encoder.
- `tx_is_k` out 1: 1 when `tx_octet` is a K code-group.
- `tx_even` out 1: 1 when the current code-group occupies an even slot.
- `TX_OSET_indicate` out 1: 1 while the last code-group of the current ordered set is on the outputs.

## Operation
- States: `GEN` (single-code-group sets), `IDLE_A`, `IDLE_B`, `CFG_A`, `CFG_B`, `CFG_C`, `CFG_D`, `FILL`.
- Sampling rule: `tx_o_set` is sampled on the rising edge that ends a cycle with `TX_OSET_indicate`=1. The first code-group of the new set is driven from that edge.
- /S/ K27.7=0xFB, /T/ K29.7=0xFD, /R/ K23.7=0xF7, /V/ K30.7=0xFE.
  - Each is one cycle with `tx_is_k`=1 and `TX_OSET_indicate`=1.
- /D/: `tx_octet`=`TXD` sampled at that edge, `tx_is_k`=0, one cycle, `TX_OSET_indicate`=1.
- /I/, 2 cycles:
  - `IDLE_A`: K28.5 (0xBC), `tx_is_k`=1, `TX_OSET_indicate`=0.
  - `IDLE_B`: data code-group, `TX_OSET_indicate`=1. It is D5.6 (0xC5, /I1/) if `tx_disparity` was 1 at the sampling edge, else D16.2 (0x50, /I2/).
- /C/, 4 cycles:
  - Sequence: K28.5, then D21.5 (0xB5, /C1/) or D2.2 (0x42, /C2/), then `cfg[7:0]`, then `cfg[15:8]`.
  - `tx_config_reg` is sampled with `tx_o_set`.
  - C1 and C2 alternate across consecutive /C/ sets; the first set after reset is C1.
  - `TX_OSET_indicate`=1 on the 4th code-group only.
- Alignment: /I/ and /C/ must start in an even slot.
  - If one is sampled when the next slot is odd, the sequencer enters `FILL` for one cycle: K23.7, `TX_OSET_indicate`=0.
  - The set then starts on the even slot. The sampled request, disparity choice and config word are held through `FILL`.
- Unknown `tx_o_set` codes are treated as /V/.

## Timing
- `tx_even` toggles every cycle without exception, including in `FILL`.
- Latency: `tx_o_set` and `TXD` to `tx_octet` is one edge.
- `TX_OSET_indicate` is high for exactly one cycle per ordered set. It is never high in `IDLE_A`, `CFG_A`–`CFG_C` or `FILL`.
- Reset, asynchronous and active-high, enters `IDLE_A` with these outputs:
  - `tx_octet`=0xBC, `tx_is_k`=1, `tx_even`=1, `TX_OSET_indicate`=0.
  - The C1/C2 toggle resets to C1.
  - After release, the first set is /I2/ (0x50 follows 0xBC) and the first sample occurs at the end of that 0x50 cycle.
- Reset asserted mid-set aborts the set immediately. No partial-set completion.
- `tx_o_set` changes while `TX_OSET_indicate`=0 are ignored.

## Configuration
- `TX_CONFIG_EN` defined: /C/ handling, the `CFG_*` states and the C1/C2 toggle are compiled in.
- `TX_CONFIG_EN` undefined: the `CFG_*` states are absent, `tx_config_reg` is unused, and `tx_os_C` is treated exactly as `tx_os_I`, including the alignment rule.

## Test plan
- Reset, then hold `tx_o_set`=I with `tx_disparity`=0 → `tx_octet` repeats 0xBC,0x50. `TX_OSET_indicate` is 0,1,0,1. `tx_even` is 1,0,1,0.
- Hold I with `tx_disparity`=1 at the sampling edges → `tx_octet` repeats 0xBC,0xC5.
- Apply S, D(0x55), D(0xAA), T, R, then I, each presented at its sampling edge → 0xFB, 0x55, 0xAA, 0xFD, 0xF7, then 0xF7 `FILL` with `TX_OSET_indicate`=0, then 0xBC on an even slot.
- With `TX_CONFIG_EN`, `tx_config_reg`=0x1234, C held → 0xBC,0xB5,0x34,0x12 then 0xBC,0x42,0x34,0x12. `TX_OSET_indicate` is high only on each 0x12.
- Without `TX_CONFIG_EN`, C held → same output as I.
- Assert reset during `CFG_C` → outputs immediately 0xBC, `tx_is_k`=1, `tx_even`=1. After release, 0x50 follows.
